// File: rtl/knn_vote_pkg.sv
// Shared constants for the KNN majority-vote block: parameter defaults,
// FSM encodings and the k clamp helper.
package knn_vote_pkg;

    localparam int K_MAX_DEF   = 10;
    localparam int LABEL_W_DEF = 4;
    localparam int IDX_W_DEF   = 8;
    localparam int CNT_W       = 4;

    localparam logic [3:0] K_MIN = 4'd1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // k=0 would vote on nothing, and k beyond the sorter depth reads empty slots.
    function automatic logic [3:0] clamp_k(input logic [3:0] k, input logic [3:0] k_max);
        if (k < K_MIN) begin
            return K_MIN;
        end
        if (k > k_max) begin
            return k_max;
        end
        return k;
    endfunction

endpackage

// File: rtl/knn_vote_hist.sv
// Per-class vote counters with a running argmax. best_cls/best_cnt already
// include the vote being applied this cycle, so they can be captured on the same edge.
module knn_vote_hist
    import knn_vote_pkg::*;
#(
    parameter int LABEL_W = LABEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [LABEL_W-1:0] label,
    output logic [LABEL_W-1:0] best_cls,
    output logic [CNT_W-1:0]   best_cnt
);

    localparam int N_CLS = 2**LABEL_W;

    logic [N_CLS*CNT_W-1:0] cnt_flat;
    logic [CNT_W-1:0]       cur_cnt;
    logic [CNT_W-1:0]       new_cnt;
    logic                   upd;
    logic [LABEL_W-1:0]     best_cls_q, best_cls_d;
    logic [CNT_W-1:0]       best_cnt_q, best_cnt_d;

    for (genvar gi = 0; gi < N_CLS; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = '0;
            end else if (en && (label == LABEL_W'(gi))) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_q;
    end

    assign cur_cnt = cnt_flat[label*CNT_W +: CNT_W];
    assign new_cnt = cur_cnt + CNT_W'(1);
    // Strictly greater keeps the class that reached a tied count first.
    assign upd     = en && !clr && (new_cnt > best_cnt_q);

    always_comb begin
        best_cls_d = best_cls_q;
        best_cnt_d = best_cnt_q;
        if (clr) begin
            best_cls_d = '0;
            best_cnt_d = '0;
        end else if (upd) begin
            best_cls_d = label;
            best_cnt_d = new_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_cls_q <= '0;
            best_cnt_q <= '0;
        end else begin
            best_cls_q <= best_cls_d;
            best_cnt_q <= best_cnt_d;
        end
    end

    assign best_cls = best_cls_d;
    assign best_cnt = best_cnt_d;

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the first k sorter slots: walks SEL, reads each
// neighbour's label one cycle later and reports the winning class.
module knn_vote
    import knn_vote_pkg::*;
#(
    parameter int K_MAX   = K_MAX_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int LABEL_W = LABEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         k,
    output logic               busy,
    output logic               done,
    output logic [3:0]         sel,
    input  logic [IDX_W-1:0]   idx_in,
    output logic [IDX_W-1:0]   lbl_addr,
    input  logic [LABEL_W-1:0] lbl_data,
    output logic [LABEL_W-1:0] class_out,
    output logic [3:0]         votes_out
);

    logic [1:0]         state_q, state_d;
    logic [3:0]         s_q, s_d;
    logic [3:0]         keff_q, keff_d;
    logic               acc_vld_q, acc_vld_d;
    logic [LABEL_W-1:0] class_q, class_d;
    logic [3:0]         votes_q, votes_d;
    logic               hist_clr;
    logic [LABEL_W-1:0] best_cls;
    logic [CNT_W-1:0]   best_cnt;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        keff_d   = keff_q;
        class_d  = class_q;
        votes_d  = votes_q;
        hist_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    keff_d   = clamp_k(k, 4'(K_MAX));
                    s_d      = '0;
                    hist_clr = 1'b1;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                s_d = s_q + 4'd1;
                if (s_q == keff_q - 4'd1) begin
                    s_d     = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last label is accumulated on this same edge; the hist
                // outputs already reflect it.
                class_d = best_cls;
                votes_d = best_cnt;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign acc_vld_d = (state_q == ST_READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            keff_q    <= '0;
            acc_vld_q <= 1'b0;
            class_q   <= '0;
            votes_q   <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            keff_q    <= keff_d;
            acc_vld_q <= acc_vld_d;
            class_q   <= class_d;
            votes_q   <= votes_d;
        end
    end

    knn_vote_hist #(
        .LABEL_W (LABEL_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr      (hist_clr),
        .en       (acc_vld_q),
        .label    (lbl_data),
        .best_cls (best_cls),
        .best_cnt (best_cnt)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign sel       = (state_q == ST_READ) ? s_q : 4'd0;
    assign lbl_addr  = idx_in;
    assign class_out = class_q;
    assign votes_out = votes_q;

endmodule

// File: tb/tb_knn_vote.sv
// Randomised and directed bench for knn_vote with a sorter stub and a
// registered-read label memory; results are compared against a vote-count model.
module tb_knn_vote;

    localparam int IDX_W   = 8;
    localparam int LABEL_W = 4;
    localparam int K_MAX   = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [3:0]         k;
    logic               busy;
    logic               done;
    logic [3:0]         sel;
    logic [IDX_W-1:0]   idx_in;
    logic [IDX_W-1:0]   lbl_addr;
    logic [LABEL_W-1:0] lbl_data;
    logic [LABEL_W-1:0] class_out;
    logic [3:0]         votes_out;

    int checks   = 0;
    int failures = 0;

    logic [IDX_W-1:0]   sorter_idx [0:K_MAX-1];
    logic [LABEL_W-1:0] lbl_mem    [0:255];
    int                 slot_base;

    int done_cyc;
    int n_done;
    int tr_len;
    int sel_tr  [0:63];
    bit busy_tr [0:63];

    knn_vote #(
        .K_MAX   (K_MAX),
        .IDX_W   (IDX_W),
        .LABEL_W (LABEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .sel       (sel),
        .idx_in    (idx_in),
        .lbl_addr  (lbl_addr),
        .lbl_data  (lbl_data),
        .class_out (class_out),
        .votes_out (votes_out)
    );

    always #5 clk = ~clk;

    always_comb idx_in = (int'(sel) < K_MAX) ? sorter_idx[int'(sel)] : '0;

    always @(posedge clk) lbl_data <= lbl_mem[lbl_addr];

    function automatic int eff_k(input int kk);
        if (kk == 0) return 1;
        if (kk > K_MAX) return K_MAX;
        return kk;
    endfunction

    // Count all votes, find the top count, then replay to see who got there first.
    function automatic void model(input int keff, output logic [3:0] cls, output logic [3:0] vts);
        int cnt [16];
        int mx;
        int l;
        mx  = 0;
        cls = '0;
        foreach (cnt[i]) cnt[i] = 0;
        for (int i = 0; i < keff; i++) cnt[int'(lbl_mem[sorter_idx[i]])]++;
        foreach (cnt[i]) if (cnt[i] > mx) mx = cnt[i];
        foreach (cnt[i]) cnt[i] = 0;
        for (int i = 0; i < keff; i++) begin
            l = int'(lbl_mem[sorter_idx[i]]);
            cnt[l]++;
            if (cnt[l] == mx) begin
                cls = 4'(l);
                break;
            end
        end
        vts = 4'(mx);
    endfunction

    task automatic set_slot(input int i, input logic [3:0] lab);
        sorter_idx[i] = 8'((slot_base + i * 25) % 256);
        lbl_mem[sorter_idx[i]] = lab;
    endtask

    task automatic set_random_slots(input int max_lab);
        slot_base = int'($urandom_range(0, 255));
        for (int i = 0; i < K_MAX; i++) set_slot(i, 4'($urandom_range(0, max_lab)));
    endtask

    // Start in the next cycle (cycle 0), then record outputs each cycle until done+linger.
    task automatic run_vote(input logic [3:0] kin, input int restart_cyc, input int linger);
        @(negedge clk);
        start    = 1'b1;
        k        = kin;
        done_cyc = -1;
        n_done   = 0;
        tr_len   = 0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            start      = (c == restart_cyc);
            sel_tr[c]  = int'(sel);
            busy_tr[c] = busy;
            tr_len     = c;
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + linger) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        k     = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, sel} !== 6'd0) begin
            failures++;
            $display("FAIL reset_ctrl: busy/done/sel=%b required 000000", {busy, done, sel});
        end
        checks++;
        if ({class_out, votes_out} !== 8'd0) begin
            failures++;
            $display("FAIL reset_result: class=%0d votes=%0d required 0/0", class_out, votes_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_majority;
        int bad_sel;
        int bad_busy;
        slot_base = 3;
        set_slot(0, 4'd3); set_slot(1, 4'd3); set_slot(2, 4'd1);
        set_slot(3, 4'd3); set_slot(4, 4'd1);
        run_vote(4'd5, -1, 2);
        checks++;
        if (done_cyc != 7) begin
            failures++;
            $display("FAIL majority_latency: done cycle %0d required 7", done_cyc);
        end
        checks++;
        if (class_out !== 4'd3 || votes_out !== 4'd3) begin
            failures++;
            $display("FAIL majority_result: class=%0d votes=%0d required 3/3", class_out, votes_out);
        end
        bad_sel  = 0;
        bad_busy = 0;
        for (int c = 1; c <= tr_len; c++) begin
            if (sel_tr[c] != ((c <= 5) ? c - 1 : 0)) bad_sel++;
            if (busy_tr[c] != (c <= 7)) bad_busy++;
        end
        checks++;
        if (bad_sel != 0) begin
            failures++;
            $display("FAIL majority_sel: %0d wrong cycles, sel[1..5] got %0d..%0d required 0..4",
                     bad_sel, sel_tr[1], sel_tr[5]);
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("FAIL majority_busy: %0d wrong cycles, required high in cycles 1..7 only", bad_busy);
        end
    endtask

    task automatic test_tie;
        slot_base = 77;
        set_slot(0, 4'd2); set_slot(1, 4'd5); set_slot(2, 4'd5); set_slot(3, 4'd2);
        run_vote(4'd4, -1, 0);
        checks++;
        if (done_cyc != 6 || class_out !== 4'd5 || votes_out !== 4'd2) begin
            failures++;
            $display("FAIL tie_first_reached: done=%0d class=%0d votes=%0d required 6/5/2",
                     done_cyc, class_out, votes_out);
        end
    endtask

    task automatic test_clamp;
        logic [3:0] ec, ev;
        int bad_sel;
        slot_base = 140;
        set_slot(0, 4'd9);
        for (int i = 1; i < K_MAX; i++) set_slot(i, 4'd6);
        run_vote(4'd0, -1, 0);
        checks++;
        if (done_cyc != 3 || class_out !== 4'd9 || votes_out !== 4'd1) begin
            failures++;
            $display("FAIL clamp_k0: done=%0d class=%0d votes=%0d required 3/9/1",
                     done_cyc, class_out, votes_out);
        end
        set_random_slots(3);
        model(K_MAX, ec, ev);
        run_vote(4'd15, -1, 0);
        bad_sel = 0;
        for (int c = 1; c <= tr_len; c++) if (sel_tr[c] != ((c <= K_MAX) ? c - 1 : 0)) bad_sel++;
        checks++;
        if (done_cyc != 12 || bad_sel != 0) begin
            failures++;
            $display("FAIL clamp_k15_timing: done=%0d sel errors=%0d required 12/0", done_cyc, bad_sel);
        end
        checks++;
        if (class_out !== ec || votes_out !== ev) begin
            failures++;
            $display("FAIL clamp_k15_result: class=%0d votes=%0d required %0d/%0d",
                     class_out, votes_out, ec, ev);
        end
    endtask

    task automatic test_start_ignored;
        logic [3:0] ec, ev;
        set_random_slots(2);
        model(6, ec, ev);
        run_vote(4'd6, 3, 6);
        checks++;
        if (n_done != 1 || done_cyc != 8) begin
            failures++;
            $display("FAIL restart_ignored: done pulses=%0d first at %0d required 1 at 8", n_done, done_cyc);
        end
        checks++;
        if (class_out !== ec || votes_out !== ev) begin
            failures++;
            $display("FAIL restart_result_hold: class=%0d votes=%0d required %0d/%0d",
                     class_out, votes_out, ec, ev);
        end
        run_vote(4'd2, -1, 0);
        run_vote(4'd3, -1, 0);
        checks++;
        if (done_cyc != 5) begin
            failures++;
            $display("FAIL start_after_done: done cycle %0d required 5", done_cyc);
        end
    endtask

    task automatic test_reset_mid;
        slot_base = 9;
        set_slot(0, 4'd12);
        run_vote(4'd1, -1, 0);
        for (int i = 0; i < K_MAX; i++) set_slot(i, 4'd7);
        @(negedge clk);
        start = 1'b1;
        k     = 4'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, sel, class_out, votes_out} !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid_read: busy=%b done=%b sel=%0d class=%0d votes=%0d required all 0",
                     busy, done, sel, class_out, votes_out);
        end
        rst = 1'b0;
        run_vote(4'd3, -1, 0);
        checks++;
        if (done_cyc != 5 || class_out !== 4'd7 || votes_out !== 4'd3) begin
            failures++;
            $display("FAIL reset_mid_recover: done=%0d class=%0d votes=%0d required 5/7/3",
                     done_cyc, class_out, votes_out);
        end
    endtask

    task automatic test_back_to_back;
        slot_base = 200;
        for (int i = 0; i < 7; i++) set_slot(i, 4'd4);
        run_vote(4'd7, -1, 0);
        checks++;
        if (class_out !== 4'd4 || votes_out !== 4'd7) begin
            failures++;
            $display("FAIL b2b_first: class=%0d votes=%0d required 4/7", class_out, votes_out);
        end
        slot_base = 31;
        set_slot(0, 4'd4); set_slot(1, 4'd2); set_slot(2, 4'd2); set_slot(3, 4'd2);
        set_slot(4, 4'd1); set_slot(5, 4'd1); set_slot(6, 4'd0);
        run_vote(4'd7, -1, 0);
        checks++;
        if (done_cyc != 9 || class_out !== 4'd2 || votes_out !== 4'd3) begin
            failures++;
            $display("FAIL b2b_second: done=%0d class=%0d votes=%0d required 9/2/3",
                     done_cyc, class_out, votes_out);
        end
    endtask

    task automatic test_random;
        logic [3:0] ec, ev;
        logic [3:0] kr;
        int ke;
        int bad;
        for (int n = 0; n < 30; n++) begin
            kr = 4'($urandom_range(0, 15));
            ke = eff_k(int'(kr));
            set_random_slots((n % 3 == 0) ? 1 : ((n % 3 == 1) ? 3 : 15));
            model(ke, ec, ev);
            run_vote(kr, -1, (n % 4 == 0) ? 1 : 0);
            bad = 0;
            for (int c = 1; c <= tr_len; c++) begin
                if (sel_tr[c] != ((c <= ke) ? c - 1 : 0)) bad++;
                if (busy_tr[c] != (c <= ke + 2)) bad++;
            end
            checks++;
            if (done_cyc != ke + 2 || n_done != 1 || bad != 0) begin
                failures++;
                $display("FAIL rand_timing[%0d]: k=%0d done=%0d pulses=%0d trace errors=%0d required %0d/1/0",
                         n, kr, done_cyc, n_done, bad, ke + 2);
            end
            checks++;
            if (class_out !== ec || votes_out !== ev) begin
                failures++;
                $display("FAIL rand_result[%0d]: k=%0d class=%0d votes=%0d required %0d/%0d",
                         n, kr, class_out, votes_out, ec, ev);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k         = 4'd0;
        slot_base = 0;
        for (int i = 0; i < 256; i++) lbl_mem[i] = '0;
        for (int i = 0; i < K_MAX; i++) sorter_idx[i] = '0;
        test_reset();
        test_majority();
        test_tie();
        test_clamp();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
